ahb_bus_matrix_in_stage: RTL and testbench

//  Slave-side input stage of the AHB bus matrix; one instance per slave port SI<n>.

---
 rtl/ahb_bus_matrix_in_stage_pkg.sv | 30 +++
 rtl/ahb_bus_matrix_in_stage.sv | 148 ++++++++++++++
 tb/tb_ahb_bus_matrix_in_stage.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_bus_matrix_in_stage_pkg.sv
// Shared AHB encodings for the bus matrix slave-port input stage, decoder,
// output stage and default slave.
package ahb_bus_matrix_in_stage_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        RESP_OKAY  = 2'b00,
        RESP_ERROR = 2'b01,
        RESP_RETRY = 2'b10,
        RESP_SPLIT = 2'b11
    } hresp_t;

    // State of the holding-register flag.
    typedef enum logic {
        ST_PASS = 1'b0,
        ST_HOLD = 1'b1
    } hold_state_t;

    // NONSEQ and SEQ both have bit 1 set; IDLE and BUSY do not.
    function automatic logic is_active_trans(input logic [1:0] trans);
        return trans[1];
    endfunction

endpackage

// File: rtl/ahb_bus_matrix_in_stage.sv
// Slave-port input stage: captures an address phase the output stage cannot
// take yet, stalls the master until granted, and returns HREADYOUTS/HRESPS.
module ahb_bus_matrix_in_stage
    import ahb_bus_matrix_in_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int MW         = 4
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSELS,
    input  logic [ADDR_WIDTH-1:0] HADDRS,
    input  logic [1:0]            HTRANSS,
    input  logic                  HWRITES,
    input  logic [2:0]            HSIZES,
    input  logic [2:0]            HBURSTS,
    input  logic [3:0]            HPROTS,
    input  logic [MW-1:0]         HMASTERS,
    input  logic                  HMASTLOCKS,
    input  logic                  HREADYS,
    output logic                  HREADYOUTS,
    output logic [1:0]            HRESPS,
    output logic                  sel_op,
    output logic [ADDR_WIDTH-1:0] addr_op,
    output logic [1:0]            trans_op,
    output logic                  write_op,
    output logic [2:0]            size_op,
    output logic [2:0]            burst_op,
    output logic [3:0]            prot_op,
    output logic [MW-1:0]         master_op,
    output logic                  mastlock_op,
    output logic                  held_tran_op,
    input  logic                  active_op,
    input  logic                  readyout_op,
    input  logic [1:0]            resp_op
);

    logic                  valid_tran;
    logic                  reg_hold;
    logic                  dphase_reg;
    hold_state_t           state_reg;
    hold_state_t           state_next;

    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [1:0]            trans_reg;
    logic                  write_reg;
    logic [2:0]            size_reg;
    logic [2:0]            burst_reg;
    logic [3:0]            prot_reg;
    logic [MW-1:0]         master_reg;
    logic                  mastlock_reg;

    assign valid_tran = HSELS & is_active_trans(HTRANSS) & HREADYS;

    // Hold flag: state register
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_reg <= ST_PASS;
        end else begin
            state_reg <= state_next;
        end
    end

    // Hold flag: next state. Entry and exit cannot coincide because the
    // stall in ST_HOLD keeps HREADYS low.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_PASS: if (valid_tran && !active_op) state_next = ST_HOLD;
            ST_HOLD: if (active_op)                state_next = ST_PASS;
            default:                               state_next = ST_PASS;
        endcase
    end

    assign reg_hold = (state_reg == ST_HOLD);

    // Address-phase copy, refreshed on every completed bus cycle.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            addr_reg     <= '0;
            trans_reg    <= '0;
            write_reg    <= 1'b0;
            size_reg     <= '0;
            burst_reg    <= '0;
            prot_reg     <= '0;
            master_reg   <= '0;
            mastlock_reg <= 1'b0;
        end else if (HREADYS) begin
            addr_reg     <= HADDRS;
            trans_reg    <= HTRANSS;
            write_reg    <= HWRITES;
            size_reg     <= HSIZES;
            burst_reg    <= HBURSTS;
            prot_reg     <= HPROTS;
            master_reg   <= HMASTERS;
            mastlock_reg <= HMASTLOCKS;
        end
    end

    // A held transfer that gets granted enters its data phase directly.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dphase_reg <= 1'b0;
        end else if (HREADYS) begin
            dphase_reg <= valid_tran & active_op;
        end else if (reg_hold && active_op) begin
            dphase_reg <= 1'b1;
        end
    end

    // Outputs: bundle mux and master-facing response
    always_comb begin
        held_tran_op = reg_hold;
        if (reg_hold) begin
            sel_op      = 1'b1;
            addr_op     = addr_reg;
            trans_op    = trans_reg;
            write_op    = write_reg;
            size_op     = size_reg;
            burst_op    = burst_reg;
            prot_op     = prot_reg;
            master_op   = master_reg;
            mastlock_op = mastlock_reg;
        end else begin
            sel_op      = HSELS;
            addr_op     = HADDRS;
            trans_op    = HTRANSS;
            write_op    = HWRITES;
            size_op     = HSIZES;
            burst_op    = HBURSTS;
            prot_op     = HPROTS;
            master_op   = HMASTERS;
            mastlock_op = HMASTLOCKS;
        end

        if (reg_hold) begin
            HREADYOUTS = 1'b0;
            HRESPS     = RESP_OKAY;
        end else if (dphase_reg) begin
            HREADYOUTS = readyout_op;
            HRESPS     = resp_op;
        end else begin
            HREADYOUTS = 1'b1;
            HRESPS     = RESP_OKAY;
        end
    end

endmodule

// File: tb/tb_ahb_bus_matrix_in_stage.sv
// Directed vector table plus randomized run against a transaction-level
// model of the slave-port input stage.
module tb_ahb_bus_matrix_in_stage;

    localparam int AW = 32;
    localparam int MW = 4;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          HSELS;
    logic [AW-1:0] HADDRS;
    logic [1:0]    HTRANSS;
    logic          HWRITES;
    logic [2:0]    HSIZES;
    logic [2:0]    HBURSTS;
    logic [3:0]    HPROTS;
    logic [MW-1:0] HMASTERS;
    logic          HMASTLOCKS;
    logic          HREADYS;
    logic          HREADYOUTS;
    logic [1:0]    HRESPS;
    logic          sel_op;
    logic [AW-1:0] addr_op;
    logic [1:0]    trans_op;
    logic          write_op;
    logic [2:0]    size_op;
    logic [2:0]    burst_op;
    logic [3:0]    prot_op;
    logic [MW-1:0] master_op;
    logic          mastlock_op;
    logic          held_tran_op;
    logic          active_op;
    logic          readyout_op;
    logic [1:0]    resp_op;

    // Single-master system: the bus HREADY is this port's own HREADYOUT.
    assign HREADYS = HREADYOUTS;

    always #5 HCLK = ~HCLK;

    ahb_bus_matrix_in_stage #(.ADDR_WIDTH(AW), .MW(MW)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSELS(HSELS), .HADDRS(HADDRS),
        .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES),
        .HBURSTS(HBURSTS), .HPROTS(HPROTS), .HMASTERS(HMASTERS),
        .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS),
        .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
        .sel_op(sel_op), .addr_op(addr_op), .trans_op(trans_op),
        .write_op(write_op), .size_op(size_op), .burst_op(burst_op),
        .prot_op(prot_op), .master_op(master_op), .mastlock_op(mastlock_op),
        .held_tran_op(held_tran_op), .active_op(active_op),
        .readyout_op(readyout_op), .resp_op(resp_op)
    );

    typedef struct {
        logic          sel;
        logic [1:0]    trans;
        logic [AW-1:0] addr;
        logic          write;
        logic          active;
        logic          ro;
        logic [1:0]    resp;
        logic          e_ready;
        logic [1:0]    e_resp;
        logic          e_held;
        logic          e_sel;
        logic [AW-1:0] e_addr;
        logic [1:0]    e_trans;
        logic          e_write;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_txn = 0;

    // Reference model: one pending address phase and a data-phase flag.
    logic        m_hold = 1'b0;
    logic        m_dp   = 1'b0;
    logic [49:0] m_stored = '0;

    function automatic vec_t mk(logic sel, logic [1:0] trans, logic [AW-1:0] addr,
                                logic write, logic active, logic ro, logic [1:0] resp,
                                logic e_ready, logic [1:0] e_resp, logic e_held,
                                logic e_sel, logic [AW-1:0] e_addr,
                                logic [1:0] e_trans, logic e_write);
        vec_t v;
        v.sel = sel; v.trans = trans; v.addr = addr; v.write = write;
        v.active = active; v.ro = ro; v.resp = resp;
        v.e_ready = e_ready; v.e_resp = e_resp; v.e_held = e_held;
        v.e_sel = e_sel; v.e_addr = e_addr; v.e_trans = e_trans; v.e_write = e_write;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [49:0] live_fields();
        return {HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTERS, HMASTLOCKS};
    endfunction

    function automatic logic [50:0] dut_bundle();
        return {sel_op, addr_op, trans_op, write_op, size_op, burst_op,
                prot_op, master_op, mastlock_op};
    endfunction

    // Called at posedge+1; applies inputs, checks at negedge, advances model at posedge.
    task automatic step(input bit use_tbl, input vec_t v);
        logic        e_ready;
        logic [1:0]  e_resp;
        logic [50:0] e_bundle;
        logic        valid;
        if (use_tbl) begin
            HSELS = v.sel; HTRANSS = v.trans; HADDRS = v.addr; HWRITES = v.write;
            active_op = v.active; readyout_op = v.ro; resp_op = v.resp;
        end
        @(negedge HCLK);
        if (m_hold) begin
            e_ready = 1'b0; e_resp = 2'b00; e_bundle = {1'b1, m_stored};
        end else if (m_dp) begin
            e_ready = readyout_op; e_resp = resp_op; e_bundle = {HSELS, live_fields()};
        end else begin
            e_ready = 1'b1; e_resp = 2'b00; e_bundle = {HSELS, live_fields()};
        end
        $display("txn %0d: sel=%0d trans=%0d addr=%h act=%0d ro=%0d -> rdy=%0d resp=%0d held=%0d addr_op=%h",
                 n_txn, HSELS, HTRANSS, HADDRS, active_op, readyout_op,
                 HREADYOUTS, HRESPS, held_tran_op, addr_op);
        n_txn++;
        if (use_tbl) begin
            chk("tbl_ready", 64'(HREADYOUTS), 64'(v.e_ready));
            chk("tbl_resp",  64'(HRESPS),     64'(v.e_resp));
            chk("tbl_held",  64'(held_tran_op), 64'(v.e_held));
            chk("tbl_sel",   64'(sel_op),     64'(v.e_sel));
            chk("tbl_addr",  64'(addr_op),    64'(v.e_addr));
            chk("tbl_trans", 64'(trans_op),   64'(v.e_trans));
            chk("tbl_write", 64'(write_op),   64'(v.e_write));
        end else begin
            chk("rnd_ready",  64'(HREADYOUTS),   64'(e_ready));
            chk("rnd_resp",   64'(HRESPS),       64'(e_resp));
            chk("rnd_held",   64'(held_tran_op), 64'(m_hold));
            chk("rnd_bundle", 64'(dut_bundle()), 64'(e_bundle));
        end
        @(posedge HCLK);
        if (m_hold) begin
            if (active_op) begin
                m_hold = 1'b0;
                m_dp   = 1'b1;
            end
        end else if (e_ready) begin
            valid    = HSELS & HTRANSS[1];
            m_stored = live_fields();
            m_dp     = valid & active_op;
            m_hold   = valid & !active_op;
        end
        #1;
    endtask

    initial begin
        vec_t dummy;
        dummy = mk(0,0,0,0,0,0,0, 0,0,0,0,0,0,0);

        // sel trans addr wr act ro resp | rdy resp held sel addr trans wr
        tbl.push_back(mk(1,2'd0,32'h0000_0000,0,1,0,2'd0, 1,2'd0,0,1,32'h0000_0000,2'd0,0));
        tbl.push_back(mk(1,2'd2,32'h1000_0000,0,1,1,2'd0, 1,2'd0,0,1,32'h1000_0000,2'd2,0));
        tbl.push_back(mk(1,2'd0,32'h0000_0000,0,1,1,2'd0, 1,2'd0,0,1,32'h0000_0000,2'd0,0));
        tbl.push_back(mk(1,2'd2,32'h0000_0040,1,0,1,2'd0, 1,2'd0,0,1,32'h0000_0040,2'd2,1));
        tbl.push_back(mk(1,2'd0,32'h0000_0999,0,0,1,2'd0, 0,2'd0,1,1,32'h0000_0040,2'd2,1));
        tbl.push_back(mk(0,2'd0,32'h0000_0999,0,0,1,2'd0, 0,2'd0,1,1,32'h0000_0040,2'd2,1));
        tbl.push_back(mk(1,2'd2,32'h0000_0080,0,1,0,2'd0, 0,2'd0,1,1,32'h0000_0040,2'd2,1));
        tbl.push_back(mk(1,2'd2,32'h0000_0080,0,1,0,2'd0, 0,2'd0,0,1,32'h0000_0080,2'd2,0));
        tbl.push_back(mk(1,2'd2,32'h0000_0080,0,1,0,2'd0, 0,2'd0,0,1,32'h0000_0080,2'd2,0));
        tbl.push_back(mk(1,2'd2,32'h0000_0080,0,1,1,2'd0, 1,2'd0,0,1,32'h0000_0080,2'd2,0));
        tbl.push_back(mk(1,2'd0,32'h0000_0000,0,1,0,2'd1, 0,2'd1,0,1,32'h0000_0000,2'd0,0));
        tbl.push_back(mk(1,2'd0,32'h0000_0000,0,1,1,2'd1, 1,2'd1,0,1,32'h0000_0000,2'd0,0));
        tbl.push_back(mk(1,2'd0,32'h0000_0000,0,1,0,2'd1, 1,2'd0,0,1,32'h0000_0000,2'd0,0));
        tbl.push_back(mk(1,2'd1,32'h0000_0010,0,1,0,2'd2, 1,2'd0,0,1,32'h0000_0010,2'd1,0));
        tbl.push_back(mk(1,2'd0,32'h0000_0000,0,1,0,2'd3, 1,2'd0,0,1,32'h0000_0000,2'd0,0));
        tbl.push_back(mk(1,2'd2,32'h0000_0100,0,1,1,2'd0, 1,2'd0,0,1,32'h0000_0100,2'd2,0));
        tbl.push_back(mk(1,2'd3,32'h0000_0104,0,1,1,2'd0, 1,2'd0,0,1,32'h0000_0104,2'd3,0));
        tbl.push_back(mk(1,2'd3,32'h0000_0108,0,1,1,2'd0, 1,2'd0,0,1,32'h0000_0108,2'd3,0));
        tbl.push_back(mk(1,2'd0,32'h0000_0000,0,1,1,2'd0, 1,2'd0,0,1,32'h0000_0000,2'd0,0));
        tbl.push_back(mk(1,2'd2,32'h0000_0200,1,0,1,2'd0, 1,2'd0,0,1,32'h0000_0200,2'd2,1));
        tbl.push_back(mk(1,2'd2,32'h0000_0300,0,1,1,2'd0, 0,2'd0,1,1,32'h0000_0200,2'd2,1));
        tbl.push_back(mk(1,2'd2,32'h0000_0300,0,0,1,2'd0, 1,2'd0,0,1,32'h0000_0300,2'd2,0));
        tbl.push_back(mk(1,2'd0,32'h0000_0000,1,0,1,2'd0, 0,2'd0,1,1,32'h0000_0300,2'd2,0));
        tbl.push_back(mk(1,2'd0,32'h0000_0000,1,1,1,2'd0, 0,2'd0,1,1,32'h0000_0300,2'd2,0));
        tbl.push_back(mk(1,2'd0,32'h0000_0000,0,1,1,2'd0, 1,2'd0,0,1,32'h0000_0000,2'd0,0));
        tbl.push_back(mk(0,2'd2,32'h0000_0500,0,1,0,2'd0, 1,2'd0,0,0,32'h0000_0500,2'd2,0));
        tbl.push_back(mk(1,2'd0,32'h0000_0000,0,1,0,2'd0, 1,2'd0,0,1,32'h0000_0000,2'd0,0));

        // Reset state
        HRESET = 1'b1; HSELS = 1'b0; HTRANSS = 2'd0; HADDRS = 32'h1234;
        HWRITES = 1'b0; HSIZES = 3'd2; HBURSTS = 3'd1; HPROTS = 4'd3;
        HMASTERS = 4'd5; HMASTLOCKS = 1'b0;
        active_op = 1'b0; readyout_op = 1'b0; resp_op = 2'd0;
        #1;
        chk("rst_ready", 64'(HREADYOUTS), 64'd1);
        chk("rst_resp",  64'(HRESPS), 64'd0);
        chk("rst_held",  64'(held_tran_op), 64'd0);
        chk("rst_addr",  64'(addr_op), 64'h1234);
        @(posedge HCLK); #1;
        HRESET = 1'b0;

        foreach (tbl[i]) step(1'b1, tbl[i]);

        // Reset asserted in the middle of a hold drops the pending transfer
        step(1'b1, mk(1,2'd2,32'h0000_0700,1,0,1,2'd0, 1,2'd0,0,1,32'h0000_0700,2'd2,1));
        HTRANSS = 2'd0; HADDRS = 32'h0000_0ABC; HWRITES = 1'b0;
        #2;
        chk("hold_pre_rst", 64'(held_tran_op), 64'd1);
        chk("hold_pre_rst_addr", 64'(addr_op), 64'h700);
        HRESET = 1'b1;
        #1;
        chk("midrst_ready", 64'(HREADYOUTS), 64'd1);
        chk("midrst_resp",  64'(HRESPS), 64'd0);
        chk("midrst_held",  64'(held_tran_op), 64'd0);
        chk("midrst_addr",  64'(addr_op), 64'hABC);
        chk("midrst_sel",   64'(sel_op), 64'd1);
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        m_hold = 1'b0; m_dp = 1'b0; m_stored = '0;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            HSELS      = ($urandom_range(0, 3) != 0);
            HTRANSS    = 2'($urandom_range(0, 3));
            HADDRS     = $urandom;
            HWRITES    = 1'($urandom_range(0, 1));
            HSIZES     = 3'($urandom_range(0, 7));
            HBURSTS    = 3'($urandom_range(0, 7));
            HPROTS     = 4'($urandom_range(0, 15));
            HMASTERS   = 4'($urandom_range(0, 15));
            HMASTLOCKS = 1'($urandom_range(0, 1));
            active_op  = ($urandom_range(0, 4) < 3);
            readyout_op = ($urandom_range(0, 9) < 7);
            resp_op    = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            step(1'b0, dummy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
